// File: rtl/kf_run_ctrl_if.sv
// Host command port of the Kalman-filter run controller: LOAD/RUN commands
// with a valid/ready handshake.
interface kf_run_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/kf_run_ctrl.sv
// Program loader and run controller for the Kalman-filter microcode sequencer.
// Writes microinstructions into the sequencer ROM, launches a run, watches for
// READY, enforces a cycle budget / host abort through a kill reset, and reports
// status, cycle count and final PC.
module kf_run_ctrl #(
  parameter int unsigned TO_W        = 16,
  parameter int unsigned NOSTART_LIM = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  kf_run_ctrl_if.slave    host,
  input  logic [TO_W-1:0] cfg_timeout,
  input  logic            abort_i,
  output logic            rom_we,
  output logic [7:0]      rom_waddr,
  output logic [15:0]     rom_wdata,
  output logic            seq_start,
  output logic            seq_rst_n,
  input  logic            seq_ready,
  input  logic [7:0]      seq_pc,
  output logic            busy,
  output logic            done,
  output logic [1:0]      status,
  output logic [31:0]     run_cycles,
  output logic [7:0]      final_pc,
  output logic            bad_op
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;
  localparam logic [1:0] ST_NOSTART = 2'b11;

  // Shared dwell counter for WAIT_LOW (no-start detection) and KILL (2 cycles).
  localparam int unsigned CW = $clog2(NOSTART_LIM + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_LOW,
    S_RUN,
    S_KILL,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_sub_cnt;
  logic [TO_W-1:0] r_timeout;
  logic            r_rom_we;
  logic [7:0]      r_rom_waddr;
  logic [15:0]     r_rom_wdata;
  logic [1:0]      r_status;
  logic [31:0]     r_run_cycles;
  logic [7:0]      r_final_pc;
  logic            r_bad_op;

  logic            w_accept;
  logic [31:0]     w_rc_inc;
  logic            w_tmo_hit;
  logic            w_count_en;
  logic            w_set_status;
  logic [1:0]      w_status_val;

  assign w_accept   = host.cmd_valid && (r_state == S_IDLE);
  assign w_rc_inc   = (r_run_cycles == '1) ? r_run_cycles : r_run_cycles + 32'd1;
  assign w_tmo_hit  = (r_timeout != '0) && (w_rc_inc >= 32'(r_timeout));
  // The WAIT_LOW cycle that first sees READY low already counts as a run cycle;
  // an abort in that same cycle wins over counting.
  assign w_count_en = ((r_state == S_WAIT_LOW) || (r_state == S_RUN)) &&
                      !seq_ready && !abort_i;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and run-termination status decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_set_status = 1'b0;
    w_status_val = ST_OK;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (host.cmd_op == OP_RUN)) w_state_nxt = S_START;
      end
      S_START: w_state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!seq_ready) begin
          if (abort_i) begin
            w_state_nxt  = S_KILL;
            w_set_status = 1'b1;
            w_status_val = ST_ABORT;
          end else if (w_tmo_hit) begin
            w_state_nxt  = S_KILL;
            w_set_status = 1'b1;
            w_status_val = ST_TIMEOUT;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else if (r_sub_cnt == CW'(NOSTART_LIM - 1)) begin
          w_state_nxt  = S_DONE;
          w_set_status = 1'b1;
          w_status_val = ST_NOSTART;
        end else if (abort_i) begin
          w_state_nxt  = S_KILL;
          w_set_status = 1'b1;
          w_status_val = ST_ABORT;
        end
      end
      S_RUN: begin
        if (seq_ready) begin
          w_state_nxt  = S_DONE;
          w_set_status = 1'b1;
          w_status_val = ST_OK;
        end else if (abort_i) begin
          w_state_nxt  = S_KILL;
          w_set_status = 1'b1;
          w_status_val = ST_ABORT;
        end else if (w_tmo_hit) begin
          w_state_nxt  = S_KILL;
          w_set_status = 1'b1;
          w_status_val = ST_TIMEOUT;
        end
      end
      S_KILL: begin
        if (r_sub_cnt == CW'(1)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    host.cmd_ready = (r_state == S_IDLE);
    busy           = (r_state != S_IDLE);
    seq_start      = (r_state == S_START);
    seq_rst_n      = (r_state != S_KILL);
    done           = (r_state == S_DONE);
  end

  // Command capture, run bookkeeping and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sub_cnt    <= '0;
      r_timeout    <= '0;
      r_rom_we     <= 1'b0;
      r_rom_waddr  <= '0;
      r_rom_wdata  <= '0;
      r_status     <= ST_OK;
      r_run_cycles <= '0;
      r_final_pc   <= '0;
      r_bad_op     <= 1'b0;
    end else begin
      r_sub_cnt <= (w_state_nxt != r_state) ? '0 : r_sub_cnt + CW'(1);

      r_rom_we <= w_accept && (host.cmd_op == OP_LOAD);
      if (w_accept && (host.cmd_op == OP_LOAD)) begin
        r_rom_waddr <= host.cmd_addr;
        r_rom_wdata <= host.cmd_data;
      end

      if (w_accept && (host.cmd_op == OP_RUN)) begin
        r_timeout    <= cfg_timeout;
        r_run_cycles <= '0;
        r_status     <= ST_OK;
        r_bad_op     <= 1'b0;
      end
      if (w_accept && host.cmd_op[1]) r_bad_op <= 1'b1;

      if (w_count_en)   r_run_cycles <= w_rc_inc;
      if (w_set_status) r_status     <= w_status_val;

      // Captured on entry to DONE so the value is already valid while done is high.
      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) r_final_pc <= seq_pc;
    end
  end

  assign rom_we     = r_rom_we;
  assign rom_waddr  = r_rom_waddr;
  assign rom_wdata  = r_rom_wdata;
  assign status     = r_status;
  assign run_cycles = r_run_cycles;
  assign final_pc   = r_final_pc;
  assign bad_op     = r_bad_op;

endmodule
